// File: rtl/run_control.sv
// ---------------------------------------------------------------------------
// run_control
//
// Run/step/load/halt sequencer that owns the program counter of a small
// teaching CPU. Two raw buttons are synchronized, debounced and turned into
// single-cycle pulses:
//   - SYS_load loads SYS_pc_val into pc.
//   - step_btn advances one instruction in single-step mode.
// A five-state FSM decides, every cycle, whether the current instruction may
// commit. It also latches the PC of faulting instructions and counts
// exceptions.
//
// Ports
//   SYS_clk     in   1     system clock, rising edge
//   SYS_rst     in   1     asynchronous reset, active low
//   SYS_load    in   1     raw PC-load button (asynchronous)
//   SYS_pc_val  in   PC_W  value loaded into pc from LOAD
//   step_btn    in   1     raw single-step button (asynchronous)
//   run_mode    in   1     1 = free run, 0 = single step (quasi-static)
//   eh_flag     in   1     exception flag for the current instruction
//   pc_next     in   PC_W  next PC from the datapath
//   pc          out  PC_W  program counter
//   commit_en   out  1     current instruction may write REG/DMEM
//   halted      out  1     high in HALT
//   epc         out  PC_W  PC of the last faulting instruction
//   exc_count   out  8     exceptions taken, saturating at 255
//   state       out  3     IDLE=0 RUN=1 STEP=2 LOAD=3 HALT=4
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// run_control_debounce
//
// 2-FF synchronizer, level debouncer and rising-edge pulse generator for one
// raw button. The accepted level changes only after DEB_CYCLES consecutive
// synchronized samples that all differ from the current level. A rising edge
// of the accepted level gives a one-cycle registered pulse. The pulse appears
// 2 + DEB_CYCLES + 1 cycles after a clean raw edge.
//
// Ports
//   SYS_clk  in   1  system clock
//   SYS_rst  in   1  asynchronous reset, active low
//   raw      in   1  raw button level
//   pulse    out  1  one-cycle pulse on an accepted 0->1 transition
// ---------------------------------------------------------------------------
module run_control_debounce #(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic SYS_clk,
   input  logic SYS_rst,
   input  logic raw,
   output logic pulse
);

   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge SYS_clk or negedge SYS_rst) begin
      if (!SYS_rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
         pulse   <= 1'b0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_d <= level;
         pulse   <= level & ~level_d;
         // cnt holds the number of consecutive differing samples seen so far.
         // The last of DEB_CYCLES such samples flips the level.
         if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

module run_control #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned PC_W       = 8
) (
   input  logic            SYS_clk,
   input  logic            SYS_rst,
   input  logic            SYS_load,
   input  logic [PC_W-1:0] SYS_pc_val,
   input  logic            step_btn,
   input  logic            run_mode,
   input  logic            eh_flag,
   input  logic [PC_W-1:0] pc_next,
   output logic [PC_W-1:0] pc,
   output logic            commit_en,
   output logic            halted,
   output logic [PC_W-1:0] epc,
   output logic [7:0]      exc_count,
   output logic [2:0]      state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_STEP = 3'd2,
      S_LOAD = 3'd3,
      S_HALT = 3'd4
   } state_t;

   state_t          cur_st;
   state_t          nxt_st;
   logic            load_p;
   logic            step_p;
   logic            exc_take;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] epc_d;
   logic [7:0]      exc_d;

   // -------------------------------------------------------------------------
   // Button conditioning
   // -------------------------------------------------------------------------
   run_control_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_load_deb (
      .SYS_clk (SYS_clk),
      .SYS_rst (SYS_rst),
      .raw     (SYS_load),
      .pulse   (load_p)
   );

   run_control_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
      .SYS_clk (SYS_clk),
      .SYS_rst (SYS_rst),
      .raw     (step_btn),
      .pulse   (step_p)
   );

   // In STEP mode, an exception counts only for an instruction that is
   // actually being stepped. Otherwise no instruction is executing.
   assign exc_take = ((cur_st == S_RUN)  & eh_flag) |
                     ((cur_st == S_STEP) & eh_flag & step_p);

   assign state = cur_st;

   // -------------------------------------------------------------------------
   // State register, together with the PC-related registers
   // -------------------------------------------------------------------------
   always_ff @(posedge SYS_clk or negedge SYS_rst) begin
      if (!SYS_rst) begin
         cur_st    <= S_IDLE;
         pc        <= '0;
         epc       <= '0;
         exc_count <= '0;
      end else begin
         cur_st    <= nxt_st;
         pc        <= pc_d;
         epc       <= epc_d;
         exc_count <= exc_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic. Priority is exception, then load, then mode change.
   // -------------------------------------------------------------------------
   always_comb begin
      nxt_st = S_IDLE;
      case (cur_st)
         S_IDLE: nxt_st = run_mode ? S_RUN : S_STEP;
         S_RUN: begin
            if (exc_take)      nxt_st = S_HALT;
            else if (load_p)   nxt_st = S_LOAD;
            else if (!run_mode) nxt_st = S_STEP;
            else               nxt_st = S_RUN;
         end
         S_STEP: begin
            if (exc_take)      nxt_st = S_HALT;
            else if (load_p)   nxt_st = S_LOAD;
            else if (run_mode) nxt_st = S_RUN;
            else               nxt_st = S_STEP;
         end
         S_LOAD: nxt_st = run_mode ? S_RUN : S_STEP;
         S_HALT: nxt_st = load_p ? S_LOAD : S_HALT;
         default: nxt_st = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs and register update values
   // -------------------------------------------------------------------------
   always_comb begin
      commit_en = 1'b0;
      halted    = 1'b0;
      pc_d      = pc;
      epc_d     = epc;
      exc_d     = exc_count;
      case (cur_st)
         S_RUN:  commit_en = ~eh_flag & ~load_p;
         S_STEP: commit_en = step_p & ~eh_flag & ~load_p;
         S_LOAD: pc_d      = SYS_pc_val;
         S_HALT: halted    = 1'b1;
         default: ;
      endcase
      // pc_next is taken as-is. Any wrap-around is the datapath's arithmetic.
      if (commit_en)
         pc_d = pc_next;
      if (exc_take) begin
         epc_d = pc;
         if (exc_count != 8'hFF)
            exc_d = exc_count + 8'd1;
      end
   end

endmodule

// File: doc/run_control.md
RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, meaning consecutive stable synchronized samples required to accept a button level.
REQ-002 SHALL have parameter PC_W, default 8, meaning PC width.
REQ-003 SYS_clk  in  1  system clock; all state updates on its rising edge.
REQ-004 SYS_rst  in  1  asynchronous, active-low reset.
REQ-005 SYS_load  in  1  raw PC-load switch/button, asynchronous to SYS_clk.
REQ-006 SYS_pc_val  in  PC_W  PC value to load.
REQ-007 step_btn  in  1  raw single-step button, asynchronous.
REQ-008 run_mode  in  1  1 = free-run, 0 = single-step; quasi-static, sampled directly.
REQ-009 eh_flag  in  1  exception flag from the exception handler for the current instruction.
REQ-010 pc_next  in  PC_W  next PC computed by the datapath (PC+1, branch or jump target).
REQ-011 pc  out  PC_W  program counter driving IMEM.
REQ-012 commit_en  out  1  current instruction may update REG/DMEM; datapath ANDs it into Reg_Write and Mem_Write.
REQ-013 halted  out  1  high while in HALT.
REQ-014 epc  out  PC_W  PC of the last faulting instruction.
REQ-015 exc_count  out  8  number of exceptions taken.
REQ-016 state  out  3  FSM state encoding: IDLE=0, RUN=1, STEP=2, LOAD=3, HALT=4.

Function
REQ-017 SYS_load and step_btn SHALL each pass through a 2-FF synchronizer, then a debouncer that changes its level only after DEB_CYCLES consecutive equal samples differing from the current level.
REQ-018 A 0->1 transition of a debounced level SHALL produce a registered one-cycle pulse (load_p, step_p); holding the button produces no further pulses.
REQ-019 Latency from a clean raw edge to its pulse SHALL be 2 + DEB_CYCLES + 1 cycles.
REQ-020 IDLE: commit_en=0; next state is RUN if run_mode=1, else STEP.
REQ-021 RUN: commit_en = ~eh_flag & ~load_p; pc <= pc_next when commit_en=1.
REQ-022 STEP: commit_en = step_p & ~eh_flag & ~load_p; pc <= pc_next only when commit_en=1; otherwise pc holds.
REQ-023 In RUN or STEP, priority SHALL be eh_flag > load_p > run_mode change.
REQ-024 Exception taken (RUN, or STEP with step_p): epc <= pc; exc_count <= exc_count+1, saturating at 255; pc holds; next state HALT.
REQ-025 load_p in RUN, STEP or HALT with no exception taken: pc holds; next state LOAD.
REQ-026 LOAD: commit_en=0; pc <= SYS_pc_val; next state RUN if run_mode=1, else STEP.
REQ-027 HALT: commit_en=0; halted=1; pc holds; eh_flag and step_p ignored; only load_p exits, to LOAD.
REQ-028 run_mode=0 in RUN SHALL move to STEP; run_mode=1 in STEP SHALL move to RUN; the transition cycle still commits per REQ-021/022.
REQ-029 PC arithmetic is performed by the datapath; pc SHALL accept pc_next verbatim, so 255 -> 0 wraps with no special handling.
REQ-030 commit_en SHALL be combinational from registered state, registered pulses and eh_flag only.
REQ-031 Unused state encodings 5-7 SHALL go to IDLE on the next cycle with commit_en=0.

Reset
REQ-032 While SYS_rst=0 (asynchronous): pc=0, state=IDLE, commit_en=0, halted=0, epc=0, exc_count=0, synchronizers, debouncers and pulses cleared.
REQ-033 Reset asserted mid-LOAD or mid-debounce SHALL abort the operation; no pulse or load occurs after release unless a fresh button edge arrives.
REQ-034 First state after release SHALL be IDLE for exactly one cycle.

Verification
REQ-035 Reset release, run_mode=1, pc_next=pc+1 model -> IDLE 1 cycle, then pc 0,1,2,... with commit_en=1; at pc=255 the next value is 0.
REQ-036 RUN at pc=0x12, eh_flag=1 for 1 cycle -> commit_en=0 that cycle, epc=0x12, exc_count=1, halted=1, pc frozen at 0x12 for 20 cycles.
REQ-037 HALT, SYS_pc_val=0x40, SYS_load held 10 cycles with DEB_CYCLES=4 -> exactly one load_p at edge+7, LOAD next cycle, pc=0x40, then RUN.
REQ-038 run_mode=0, three step_btn presses with 2-cycle glitches between presses -> pc advances exactly 3, commit_en high exactly 3 single cycles; glitches ignored.
REQ-039 eh_flag and load_p in the same RUN cycle -> exception taken (epc captured, HALT); load not performed.
REQ-040 exc_count preset by 255 exceptions, one more exception -> exc_count stays 255; SYS_rst pulsed during LOAD -> all outputs zero, state IDLE.
